// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter and its per-source result FIFOs.
package wb_arbiter_pkg;

  localparam int NB_FU       = 4;
  localparam int NR_WB_PORTS = 2;
  localparam int WB_ID_W     = 5;
  localparam int WB_DATA_W   = 64;

  // A single-source configuration still needs a 1-bit source index field.
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_IDX_W = src_idx_w(NB_FU);

  typedef struct packed {
    logic [WB_ID_W-1:0]   id;
    logic [WB_DATA_W-1:0] data;
  } wb_arbiter_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source circular result buffer with synchronous flush.
// Latency: enqueued entry visible at head one cycle later (no bypass).
// Backpressure: enq ignored when full, even if a dequeue happens in the same cycle.
module wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_dat,
  input  logic                     deq,
  output logic [WIDTH-1:0]         deq_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_enq;
  logic             do_deq;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_enq  = enq && !full && !flush;
  assign do_deq  = deq && !empty && !flush;
  assign deq_dat = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_dat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter mapping NR_SRC buffered FU results onto NR_PORTS writeback ports.
// Latency: 1 cycle from src_valid_i to wb_valid_o minimum; flush blanks wb_valid_o in the same cycle.
// Backpressure: src_ready_o from registered FIFO count only; writeback ports always consume.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NR_SRC    = NB_FU,
  parameter int NR_PORTS  = NR_WB_PORTS,
  parameter int BUF_DEPTH = 2,
  parameter int ID_W      = WB_ID_W,
  parameter int DATA_W    = WB_DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [NR_SRC-1:0]                     src_valid_i,
  output logic [NR_SRC-1:0]                     src_ready_o,
  input  logic [NR_SRC*ID_W-1:0]                src_id_i,
  input  logic [NR_SRC*DATA_W-1:0]              src_data_i,
  output logic [NR_PORTS-1:0]                   wb_valid_o,
  output logic [NR_PORTS*ID_W-1:0]              wb_id_o,
  output logic [NR_PORTS*DATA_W-1:0]            wb_data_o,
  output logic [NR_PORTS*src_idx_w(NR_SRC)-1:0] wb_src_o,
  output logic [31:0]                           conflict_cnt_o
);

  localparam int IDX_W = src_idx_w(NR_SRC);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             head  [NR_SRC];
  logic [CNT_W-1:0]   count [NR_SRC];
  logic [NR_SRC-1:0]  empty;
  logic [NR_SRC-1:0]  full;
  logic [NR_SRC-1:0]  grant;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   last_idx;
  logic [31:0]        conflict_add;
  logic [32:0]        conflict_sum;
  int                 n_grant;
  int                 n_pend;
  int                 idx;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    entry_t in_e;
    assign in_e.id   = src_id_i[i*ID_W +: ID_W];
    assign in_e.data = src_data_i[i*DATA_W +: DATA_W];

    wb_src_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(entry_t))
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_i),
      .enq     (src_valid_i[i] && !full[i]),
      .enq_dat (in_e),
      .deq     (grant[i]),
      .deq_dat (head[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .count   (count[i])
    );

    assign src_ready_o[i] = (count[i] != CNT_W'(BUF_DEPTH));
  end

  // Scan from rr_ptr; the k-th non-empty source found drives port k.
  always_comb begin
    grant      = '0;
    wb_valid_o = '0;
    wb_id_o    = '0;
    wb_data_o  = '0;
    wb_src_o   = '0;
    n_grant    = 0;
    n_pend     = 0;
    last_idx   = rr_ptr;
    idx        = 0;
    for (int k = 0; k < NR_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NR_SRC) idx = idx - NR_SRC;
      if (!empty[idx]) begin
        n_pend = n_pend + 1;
        if (n_grant < NR_PORTS) begin
          grant[idx]                           = 1'b1;
          wb_valid_o[n_grant]                  = 1'b1;
          wb_id_o[n_grant*ID_W +: ID_W]        = head[idx].id;
          wb_data_o[n_grant*DATA_W +: DATA_W]  = head[idx].data;
          wb_src_o[n_grant*IDX_W +: IDX_W]     = IDX_W'(idx);
          last_idx                             = IDX_W'(idx);
          n_grant                              = n_grant + 1;
        end
      end
    end
    if (flush_i) begin
      grant      = '0;
      wb_valid_o = '0;
      wb_id_o    = '0;
      wb_data_o  = '0;
      wb_src_o   = '0;
    end
  end

  always_comb begin
    conflict_add = flush_i ? 32'd0 : 32'(n_pend - n_grant);
    conflict_sum = {1'b0, conflict_cnt_o} + {1'b0, conflict_add};
    if (flush_i) begin
      rr_next = '0;
    end else if (n_grant != 0) begin
      rr_next = (last_idx == IDX_W'(NR_SRC - 1)) ? '0 : last_idx + IDX_W'(1);
    end else begin
      rr_next = rr_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      conflict_cnt_o <= '0;
    end else begin
      rr_ptr         <= rr_next;
      conflict_cnt_o <= conflict_sum[32] ? 32'hFFFF_FFFF : conflict_sum[31:0];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single result, contention, backpressure, async reset, flush.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int IW = 5;
  localparam int DW = 64;
  localparam int XW = SRC_IDX_W;

  logic            clk;
  logic            rst;
  logic            flush_i;
  logic [NS-1:0]   src_valid_i;
  logic [NS-1:0]   src_ready_o;
  logic [NS*IW-1:0] src_id_i;
  logic [NS*DW-1:0] src_data_i;
  logic [NP-1:0]   wb_valid_o;
  logic [NP*IW-1:0] wb_id_o;
  logic [NP*DW-1:0] wb_data_o;
  logic [NP*XW-1:0] wb_src_o;
  logic [31:0]     conflict_cnt_o;

  int checks;
  int failures;

  wb_arbiter #(
    .NR_SRC(NS), .NR_PORTS(NP), .BUF_DEPTH(2), .ID_W(IW), .DATA_W(DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .src_id_i       (src_id_i),
    .src_data_i     (src_data_i),
    .wb_valid_o     (wb_valid_o),
    .wb_id_o        (wb_id_o),
    .wb_data_o      (wb_data_o),
    .wb_src_o       (wb_src_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int i, input logic [IW-1:0] id, input logic [DW-1:0] data);
    src_id_i[i*IW +: IW]   = id;
    src_data_i[i*DW +: DW] = data;
  endtask

  int q [NS][$];
  int seq [NS];
  int pushed;
  int popped;
  logic saw_stall;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush_i = 1'b0; src_valid_i = '0; src_id_i = '0; src_data_i = '0;
    pushed = 0; popped = 0; saw_stall = 1'b0;
    for (int i = 0; i < NS; i++) seq[i] = 0;
    #23 rst = 1'b0;
    #1;

    // Reset state
    chk("rst_wb_valid", wb_valid_o, 2'b00);
    chk("rst_ready", src_ready_o, 4'b1111);
    chk("rst_conflict", conflict_cnt_o, 32'd0);

    // Single result from src0
    tick();
    src_valid_i = 4'b0001;
    set_src(0, 5'd3, 64'hDEAD);
    tick();
    src_valid_i = '0;
    #1;
    chk("single_valid", wb_valid_o, 2'b01);
    chk("single_id", wb_id_o[0 +: IW], 5'd3);
    chk("single_data", wb_data_o[0 +: DW], 64'hDEAD);
    chk("single_src", wb_src_o[0 +: XW], 2'd0);
    chk("single_p1_zero", {wb_id_o[IW +: IW], wb_data_o[DW +: DW], wb_src_o[XW +: XW]}, 64'd0);
    tick();
    chk("single_drained", wb_valid_o, 2'b00);
    chk("single_conflict", conflict_cnt_o, 32'd0);

    // Contention: bring rr_ptr back to 0 with a flush, then all four push at once
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("cont_rr0", dut.rr_ptr, 2'd0);
    src_valid_i = 4'b1111;
    for (int i = 0; i < NS; i++) set_src(i, IW'(i + 1), 64'h100 + 64'(i));
    tick();
    src_valid_i = '0;
    #1;
    chk("cont_c1_valid", wb_valid_o, 2'b11);
    chk("cont_c1_ids", wb_id_o, {5'd2, 5'd1});
    chk("cont_c1_src", wb_src_o, {2'd1, 2'd0});
    chk("cont_c1_data1", wb_data_o[DW +: DW], 64'h101);
    tick();
    chk("cont_conflict2", conflict_cnt_o, 32'd2);
    chk("cont_c2_valid", wb_valid_o, 2'b11);
    chk("cont_c2_ids", wb_id_o, {5'd4, 5'd3});
    chk("cont_c2_src", wb_src_o, {2'd3, 2'd2});
    tick();
    chk("cont_rr_end", dut.rr_ptr, 2'd0);
    chk("cont_c3_valid", wb_valid_o, 2'b00);
    chk("cont_conflict_hold", conflict_cnt_o, 32'd2);

    // Backpressure: all sources push every cycle, scoreboard per-source id order
    for (int cyc = 0; cyc < 40; cyc++) begin
      int sz [NS];
      logic [NS-1:0] exp_rdy;
      for (int i = 0; i < NS; i++) begin
        sz[i] = q[i].size();
        exp_rdy[i] = (sz[i] != 2);
      end
      chk("bp_ready", src_ready_o, exp_rdy);
      if (exp_rdy != 4'hF) saw_stall = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (wb_valid_o[p]) begin
          int s;
          int exp_id;
          s = int'(wb_src_o[p*XW +: XW]);
          exp_id = (q[s].size() != 0) ? q[s].pop_front() : -1;
          chk("bp_id", 64'(wb_id_o[p*IW +: IW]), 64'(exp_id));
          popped++;
        end
      end
      src_valid_i = (cyc < 16) ? 4'hF : 4'h0;
      for (int i = 0; i < NS; i++) begin
        logic [IW-1:0] idv;
        idv = IW'(i * 8 + (seq[i] % 8));
        set_src(i, idv, 64'(idv) * 64'd7);
        if (cyc < 16 && sz[i] != 2) begin
          q[i].push_back(int'(idv));
          seq[i]++;
          pushed++;
        end
      end
      tick();
    end
    src_valid_i = '0;
    chk("bp_drained", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);
    chk("bp_count", 64'(popped), 64'(pushed));
    chk("bp_stalled", saw_stall, 1'b1);
    chk("bp_idle", wb_valid_o, 2'b00);

    // Asynchronous reset mid-cycle while both ports are valid
    src_valid_i = 4'b0011;
    set_src(0, 5'd7, 64'h77);
    set_src(1, 5'd8, 64'h88);
    tick();
    src_valid_i = '0;
    #1;
    chk("arst_pre_valid", wb_valid_o, 2'b11);
    rst = 1'b1;
    #1;
    chk("arst_valid", wb_valid_o, 2'b00);
    chk("arst_ids", wb_id_o, 10'd0);
    chk("arst_ready", src_ready_o, 4'b1111);
    chk("arst_conflict", conflict_cnt_o, 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("arst_post1", wb_valid_o, 2'b00);
    tick();
    chk("arst_post2", wb_valid_o, 2'b00);

    // Flush with three FIFOs non-empty; concurrent enqueue is dropped
    src_valid_i = 4'b0111;
    set_src(0, 5'd9, 64'h9);
    set_src(1, 5'd10, 64'hA);
    set_src(2, 5'd11, 64'hB);
    tick();
    src_valid_i = 4'b1000;
    set_src(3, 5'd12, 64'hC);
    flush_i = 1'b1;
    #1;
    chk("flush_same_cycle", wb_valid_o, 2'b00);
    tick();
    flush_i = 1'b0;
    src_valid_i = '0;
    #1;
    chk("flush_ready", src_ready_o, 4'b1111);
    chk("flush_valid", wb_valid_o, 2'b00);
    chk("flush_rr", dut.rr_ptr, 2'd0);
    chk("flush_conflict", conflict_cnt_o, 32'd0);
    tick();
    chk("flush_dropped", wb_valid_o, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
